// File: rtl/music_pkg.sv
// Shared widths, sequencer state codes and ROM word markers for the music datapath.
// Pure declarations: no logic, no latency, no flow control.
// State codes are plain 3-bit constants so older netlists can still decode them.
package music_pkg;

    localparam int SONG_W = 2;
    localparam int IDX_W  = 5;
    localparam int NOTE_W = 6;
    localparam int DUR_W  = 6;

    typedef logic [2:0] state_t;

    localparam state_t IDLE      = 3'd0;
    localparam state_t FETCH     = 3'd1;
    localparam state_t READ      = 3'd2;
    localparam state_t LOAD      = 3'd3;
    localparam state_t WAIT_DONE = 3'd4;
    localparam state_t NEXT      = 3'd5;
    localparam state_t END       = 3'd6;
    localparam state_t STOPPED   = 3'd7;

    localparam logic [DUR_W-1:0]  END_MARKER_DUR = '0;
    localparam logic [NOTE_W-1:0] REST_NOTE      = '0;

endpackage

// File: rtl/note_sequencer.sv
// Walks a song ROM and hands {note, duration} words to the note player.
// Latency: play seen in IDLE -> load pulse 3 cycles later; done -> next load 4 cycles later.
// Backpressure: play=0 stalls IDLE/FETCH/LOAD; one note in flight until done_with_note.
module note_sequencer
    import music_pkg::*;
(
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    play,
    input  logic [SONG_W-1:0]       song,
    output logic [SONG_W+IDX_W-1:0] rom_addr,
    input  logic [NOTE_W+DUR_W-1:0] rom_data,
    output logic [NOTE_W-1:0]       note_to_load,
    output logic [DUR_W-1:0]        duration_to_load,
    output logic                    load_new_note,
    input  logic                    done_with_note,
    output logic                    song_done
);

    state_t              state;
    logic [IDX_W-1:0]    idx;
    logic [SONG_W-1:0]   song_reg;
    logic [NOTE_W-1:0]   rom_note;
    logic [DUR_W-1:0]    rom_dur;
    logic                song_change;

    assign {rom_note, rom_dur} = rom_data;
    assign rom_addr            = {song_reg, idx};
    assign song_change         = (song != song_reg);

    // A paused LOAD holds the pulse back until play returns.
    assign load_new_note = (state == LOAD) && play;
    assign song_done     = (state == END);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state            <= IDLE;
            idx              <= '0;
            song_reg         <= '0;
            note_to_load     <= '0;
            duration_to_load <= '0;
        end else if (song_change) begin
            // Song select wins over everything; output note registers are left alone.
            song_reg <= song;
            idx      <= '0;
            state    <= IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (play) state <= FETCH;
                end
                FETCH: begin
                    if (play) state <= READ;
                end
                READ: begin
                    if (rom_dur == END_MARKER_DUR) begin
                        state <= END;
                    end else begin
                        note_to_load     <= rom_note;
                        duration_to_load <= rom_dur;
                        state            <= LOAD;
                    end
                end
                LOAD: begin
                    if (play) state <= WAIT_DONE;
                end
                WAIT_DONE: begin
                    if (done_with_note) state <= NEXT;
                end
                NEXT: begin
                    // Last slot ends the song without wrapping the index.
                    if (&idx) begin
                        state <= END;
                    end else begin
                        idx   <= idx + 1'b1;
                        state <= FETCH;
                    end
                end
                END:     state <= STOPPED;
                STOPPED: state <= STOPPED;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_note_sequencer.sv
// Directed bench for note_sequencer: behavioural 1-cycle song ROM, delayed-done player model,
// and a queue of expected {note, duration} loads checked against every observed load pulse.
module tb_note_sequencer;
    import music_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                    reset     = 1'b1;
    logic                    play      = 1'b1;
    logic [SONG_W-1:0]       song      = '0;
    logic                    man_done  = 1'b0;
    logic                    player_en = 1'b0;
    int                      player_n  = 3;
    logic                    player_done = 1'b0;
    int                      pcnt = 0;
    logic                    done_with_note;
    logic [SONG_W+IDX_W-1:0] rom_addr;
    logic [NOTE_W+DUR_W-1:0] rom_data;
    logic [NOTE_W-1:0]       note_to_load;
    logic [DUR_W-1:0]        duration_to_load;
    logic                    load_new_note;
    logic                    song_done;

    assign done_with_note = player_done | man_done;

    note_sequencer dut (
        .clk              (clk),
        .reset            (reset),
        .play             (play),
        .song             (song),
        .rom_addr         (rom_addr),
        .rom_data         (rom_data),
        .note_to_load     (note_to_load),
        .duration_to_load (duration_to_load),
        .load_new_note    (load_new_note),
        .done_with_note   (done_with_note),
        .song_done        (song_done)
    );

    // Song ROM: 4 songs x 32 words, registered read.
    logic [NOTE_W+DUR_W-1:0] rom [0:127];
    initial begin
        for (int i = 0; i < 128; i++) rom[i] = '0;
        rom[0]  = {6'd5, 6'd5};
        rom[1]  = {6'd7, 6'd3};
        rom[2]  = {6'd9, 6'd0};
        rom[32] = {6'd10, 6'd4};
        rom[33] = {6'd0, 6'd2};
        rom[34] = {6'd12, 6'd0};
        for (int i = 0; i < 32; i++) rom[64+i] = {6'(i+1), 6'((i % 5) + 1)};
        rom[96] = {6'd33, 6'd9};
    end
    always @(posedge clk) rom_data <= rom[rom_addr];

    // Player: done pulse player_n cycles after each accepted load.
    always @(posedge clk) begin
        if (player_en && load_new_note) pcnt <= player_n;
        else if (pcnt != 0)             pcnt <= pcnt - 1;
        player_done <= (pcnt == 1);
    end

    // Monitor: records loads, song_done pulses and their distance from the last done.
    int cyc = 0;
    int load_cnt = 0, sd_cnt = 0;
    int last_done_cyc = 0, last_load_cyc = 0, load_gap = 0, sd_gap = 0;
    logic [NOTE_W-1:0] obs_note [0:63];
    logic [DUR_W-1:0]  obs_dur  [0:63];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (done_with_note) last_done_cyc <= cyc;
        if (load_new_note) begin
            obs_note[load_cnt[5:0]] <= note_to_load;
            obs_dur[load_cnt[5:0]]  <= duration_to_load;
            load_cnt      <= load_cnt + 1;
            last_load_cyc <= cyc;
            load_gap      <= cyc - last_done_cyc;
        end
        if (song_done) begin
            sd_cnt <= sd_cnt + 1;
            sd_gap <= cyc - last_done_cyc;
        end
    end

    int n_chk  = 0;
    int n_fail = 0;
    int rd     = 0;
    logic [NOTE_W+DUR_W-1:0] exp_q [$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic drain();
        logic [NOTE_W+DUR_W-1:0] e;
        while (rd < load_cnt) begin
            chk("load_was_expected", 32'(exp_q.size() != 0), 1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("load_note", 32'(obs_note[rd[5:0]]), 32'(e[NOTE_W+DUR_W-1:DUR_W]));
                chk("load_dur",  32'(obs_dur[rd[5:0]]),  32'(e[DUR_W-1:0]));
            end
            rd++;
        end
    endtask

    task automatic wait_loads(input string tag, input int k, input int budget);
        for (int i = 0; i < budget && load_cnt < k; i++) begin
            @(negedge clk);
            #1;
        end
        chk(tag, 32'(load_cnt >= k), 1);
        step(1);
    endtask

    task automatic wait_sd(input string tag, input int k, input int budget);
        for (int i = 0; i < budget && sd_cnt < k; i++) begin
            @(negedge clk);
            #1;
        end
        chk(tag, 32'(sd_cnt >= k), 1);
        step(1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int rel_cyc, p_cyc, n0, sd0;

        // 1. Reset state and basic load
        step(3);
        chk("rst_rom_addr", 32'(rom_addr), 0);
        chk("rst_note", 32'(note_to_load), 0);
        chk("rst_dur", 32'(duration_to_load), 0);
        chk("rst_load", 32'(load_new_note), 0);
        chk("rst_song_done", 32'(song_done), 0);
        exp_q.push_back({6'd5, 6'd5});
        reset   = 1'b0;
        rel_cyc = cyc;
        wait_loads("t1_load_seen", 1, 20);
        chk("t1_load_latency", 32'(last_load_cyc - rel_cyc), 3);
        drain();
        step(10);
        chk("t1_single_load", 32'(load_cnt), 1);
        chk("t1_note_held", 32'(note_to_load), 5);
        chk("t1_dur_held", 32'(duration_to_load), 5);

        // 2. Sequencing, rest note and end marker on song 1
        player_en = 1'b1;
        player_n  = 3;
        sd0 = sd_cnt;
        exp_q.push_back({6'd10, 6'd4});
        exp_q.push_back({6'd0, 6'd2});
        song = 2'd1;
        wait_loads("t2_loads_seen", 3, 100);
        drain();
        chk("t2_gap_after_done", 32'(load_gap), 4);
        wait_sd("t2_song_done_seen", sd0 + 1, 50);
        chk("t2_end_latency", 32'(sd_gap), 4);
        step(10);
        chk("t2_no_third_load", 32'(load_cnt), 3);
        chk("t2_single_song_done", 32'(sd_cnt), 32'(sd0 + 1));

        // 3. Pause in FETCH and done accepted while paused
        player_en = 1'b0;
        song = 2'd0;
        step(2);
        play = 1'b0;
        n0 = load_cnt;
        step(20);
        chk("t3_no_load_paused", 32'(load_cnt), 32'(n0));
        exp_q.push_back({6'd5, 6'd5});
        play  = 1'b1;
        p_cyc = cyc;
        wait_loads("t3_load_seen", n0 + 1, 20);
        chk("t3_resume_latency", 32'(last_load_cyc - p_cyc), 2);
        drain();
        play = 1'b0;
        step(2);
        man_done = 1'b1;
        step(1);
        man_done = 1'b0;
        step(5);
        chk("t3_no_load_after_done", 32'(load_cnt), 32'(n0 + 1));
        exp_q.push_back({6'd7, 6'd3});
        play  = 1'b1;
        p_cyc = cyc;
        wait_loads("t3_second_load_seen", n0 + 2, 20);
        chk("t3_second_latency", 32'(last_load_cyc - p_cyc), 2);
        drain();

        // 4. Song change in WAIT_DONE with a coincident done
        exp_q.push_back({6'd1, 6'd1});
        song = 2'd2;
        n0 = load_cnt;
        wait_loads("t4_song2_load_seen", n0 + 1, 20);
        drain();
        song     = 2'd3;
        man_done = 1'b1;
        step(1);
        man_done = 1'b0;
        chk("t4_rom_addr", 32'(rom_addr), 96);
        exp_q.push_back({6'd33, 6'd9});
        wait_loads("t4_song3_load_seen", n0 + 2, 20);
        drain();

        // 5. Full 32-word song without an end marker
        player_en = 1'b1;
        player_n  = 2;
        sd0 = sd_cnt;
        n0  = load_cnt;
        for (int i = 0; i < 32; i++) exp_q.push_back(rom[64+i]);
        song = 2'd2;
        wait_loads("t5_loads_seen", n0 + 32, 800);
        drain();
        wait_sd("t5_song_done_seen", sd0 + 1, 50);
        chk("t5_idx_no_wrap", 32'(rom_addr), 95);
        step(10);
        chk("t5_no_extra_load", 32'(load_cnt), 32'(n0 + 32));
        chk("t5_single_song_done", 32'(sd_cnt), 32'(sd0 + 1));

        // 6. Asynchronous reset while held in LOAD
        player_en = 1'b0;
        song = 2'd3;
        play = 1'b1;
        step(3);
        play = 1'b0;
        step(1);
        chk("t6_note_latched", 32'(note_to_load), 33);
        chk("t6_dur_latched", 32'(duration_to_load), 9);
        chk("t6_load_held_low", 32'(load_new_note), 0);
        #1 reset = 1'b1;
        #1;
        chk("t6_arst_note", 32'(note_to_load), 0);
        chk("t6_arst_dur", 32'(duration_to_load), 0);
        chk("t6_arst_rom_addr", 32'(rom_addr), 0);
        chk("t6_arst_load", 32'(load_new_note), 0);
        chk("t6_arst_song_done", 32'(song_done), 0);
        n0 = load_cnt;
        exp_q.push_back({6'd33, 6'd9});
        play  = 1'b1;
        reset = 1'b0;
        wait_loads("t6_restart_load_seen", n0 + 1, 20);
        drain();
        chk("t6_restart_idx0", 32'(rom_addr), 96);

        chk("scoreboard_empty", 32'(exp_q.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
